alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result half-width (legal 8..64, even).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: operation  input  5  opcode.
REQ-007 SHALL have port: Op1  input  WIDTH  first operand (rs/ft).
REQ-008 SHALL have port: Op2  input  WIDTH  second operand (rt/fs/immediate).
REQ-009 SHALL have port: shamt  input  log2(WIDTH)  shift amount.
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: EXE_Result  output  2*WIDTH  result; high half zero unless stated.
REQ-013 SHALL have port: EXE_Zero  output  1  zero flag.
REQ-014 SHALL have port: Overflow  output  1  signed overflow flag.
REQ-015 SHALL have port: div_zero  output  1  divide by zero flag.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, DONE; in_ready = (state==IDLE).
REQ-017 SHALL accept a request on a rising edge with in_valid&&in_ready; operands and opcode latched internally; inputs may change afterwards.
REQ-018 SHALL, for single-cycle ops, register the result at the accept edge and enter DONE (out_valid high the next cycle).
REQ-019 SHALL support ops: 1 Op2<<16; 2 OR; 3 signed Op1+Op2; 4 AND; 5 signed Op2-Op1; 6 Op2<<shamt; 7 Op2>>shamt; 8 signed SLT Op1<Op2; 9 unsigned SLT; a NOR; b pass Op2; e Op2>>>shamt arithmetic; f multiply; 10 divide; 16 pass Op1; all other opcodes -> result 0, flags 0, one-cycle.
REQ-020 SHALL compute Overflow for ops 3/5 from the actual WIDTH-bit sum: operands of effective equal sign, result sign differs -> 1; otherwise 0.
REQ-021 SHALL set EXE_Zero for op 5 iff the WIDTH-bit difference is 0, regardless of Overflow; for op f/10 iff full 2*WIDTH result is 0; else 0.
REQ-022 SHALL compute op f as unsigned Op1*Op2, full 2*WIDTH product, by shift-add, exactly WIDTH cycles in MUL, then DONE.
REQ-023 SHALL compute op 10 as signed Op1/Op2 by restoring division on magnitudes, exactly WIDTH cycles in DIV, then DONE; quotient in [WIDTH-1:0] truncated toward zero, remainder in [2*WIDTH-1:WIDTH] with sign of Op1.
REQ-024 SHALL, on Op2==0 for op 10, skip DIV, enter DONE next cycle with quotient all-ones, remainder Op1, div_zero=1; div_zero 0 for all other cases.
REQ-025 SHALL, for Op1=most-negative, Op2=-1, return quotient most-negative, remainder 0, Overflow=1.
REQ-026 SHALL hold EXE_Result and flags stable while out_valid=1 and out_ready=0.
REQ-027 SHALL leave DONE for IDLE on out_valid&&out_ready; in_ready rises the following cycle (no same-cycle accept).
REQ-028 SHALL ignore in_valid while busy; no request lost since in_ready=0.

Reset
REQ-029 SHALL, on rst_n low at any time including mid MUL/DIV, go to IDLE asynchronously, abandoning the operation.
REQ-030 SHALL reset values: out_valid 0, in_ready 1 after reset, EXE_Result 0, EXE_Zero 0, Overflow 0, div_zero 0, iteration counter 0.

Configuration
REQ-031 SHALL, with ALU_MULTICYCLE_DIV_EN defined, implement op 10 per REQ-023..025.
REQ-032 SHALL, without ALU_MULTICYCLE_DIV_EN, treat op 10 as unsupported (one-cycle, result 0, div_zero 0), DIV state and divider logic absent.

Verification (WIDTH=32)
REQ-033 SHALL check op 3 Op1=0x7FFFFFFF, Op2=1 -> result 0x80000000, Overflow=1, out_valid one cycle after accept.
REQ-034 SHALL check op 5 Op1=5, Op2=5 -> result 0, EXE_Zero=1; Op1=1, Op2=0x80000000 -> Overflow=1.
REQ-035 SHALL check op f Op1=0xFFFFFFFF, Op2=0xFFFFFFFF -> 0xFFFFFFFE00000001, out_valid exactly 33 cycles after accept, in_ready 0 throughout.
REQ-036 SHALL check op 10 Op1=-7, Op2=2 -> quotient -3, remainder -1; Op2=0 -> quotient 0xFFFFFFFF, remainder -7, div_zero=1.
REQ-037 SHALL check out_ready held 0 for 5 cycles after op e Op2=0x80000000, shamt=4 -> result 0xF8000000 stable, then accept and return to IDLE.
REQ-038 SHALL check rst_n asserted mid-DIV at iteration 10 -> out_valid 0 immediately, in_ready 1 after release, next op 2 completes correctly.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle ALU with shift-add multiply and optional restoring divide (ALU_MULTICYCLE_DIV_EN)
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               operation,
  input  logic [WIDTH-1:0]         Op1,
  input  logic [WIDTH-1:0]         Op2,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       EXE_Result,
  output logic                     EXE_Zero,
  output logic                     Overflow,
  output logic                     div_zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef ALU_MULTICYCLE_DIV_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t             r_state, w_next, w_start;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_res;
  logic               r_zero, r_ovf, r_dz;
  logic               w_accept, w_last;
  logic [WIDTH-1:0]   w_sum, w_diff, w_lo, w_hi, w_lo_init;
  logic               w_ovf, w_zero, w_dz;
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mnext;

  assign w_accept   = in_valid && in_ready;
  assign w_last     = r_cnt == CW'(WIDTH - 1);
  assign w_sum      = Op1 + Op2;
  assign w_diff     = Op2 - Op1;
  assign w_madd     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_mnext    = {w_madd, r_lo[WIDTH-1:1]};
  assign in_ready   = r_state == IDLE;
  assign out_valid  = r_state == DONE;
  assign EXE_Result = r_res;
  assign EXE_Zero   = r_zero;
  assign Overflow   = r_ovf;
  assign div_zero   = r_dz;

`ifdef ALU_MULTICYCLE_DIV_EN
  logic [WIDTH-1:0] r_b, w_abs1, w_abs2, w_dhi, w_dlo, w_q, w_r;
  logic [WIDTH:0]   w_rsh, w_rsub;
  logic             r_nq, r_nr, r_dovf, w_ge;

  assign w_abs1    = Op1[WIDTH-1] ? -Op1 : Op1;
  assign w_abs2    = Op2[WIDTH-1] ? -Op2 : Op2;
  assign w_rsh     = {r_hi, r_lo[WIDTH-1]};
  assign w_rsub    = w_rsh - {1'b0, r_b};
  assign w_ge      = !w_rsub[WIDTH];
  assign w_dhi     = w_ge ? w_rsub[WIDTH-1:0] : w_rsh[WIDTH-1:0];
  assign w_dlo     = {r_lo[WIDTH-2:0], w_ge};
  assign w_q       = r_nq ? -w_dlo : w_dlo;
  assign w_r       = r_nr ? -w_dhi : w_dhi;
  assign w_lo_init = (operation == 5'h10) ? w_abs1 : Op2;
  assign w_start   = (operation == 5'h0f) ? MUL : (operation == 5'h10 && Op2 != '0) ? DIV : DONE;

  // Divisor magnitude and result sign/overflow fixups captured at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b    <= '0;
      r_nq   <= 1'b0;
      r_nr   <= 1'b0;
      r_dovf <= 1'b0;
    end else if (w_accept) begin
      r_b    <= w_abs2;
      r_nq   <= Op1[WIDTH-1] ^ Op2[WIDTH-1];
      r_nr   <= Op1[WIDTH-1];
      r_dovf <= Op1 == {1'b1, {(WIDTH-1){1'b0}}} && &Op2;
    end
  end
`else
  assign w_lo_init = Op2;
  assign w_start   = (operation == 5'h0f) ? MUL : DONE;
`endif

  // Single-cycle result and flags, evaluated on the request inputs
  always_comb begin
    w_lo   = '0;
    w_hi   = '0;
    w_ovf  = 1'b0;
    w_zero = 1'b0;
    w_dz   = 1'b0;
    case (operation)
      5'h01: w_lo = Op2 << 16;
      5'h02: w_lo = Op1 | Op2;
      5'h03: begin
        w_lo  = w_sum;
        w_ovf = (Op1[WIDTH-1] == Op2[WIDTH-1]) && (w_sum[WIDTH-1] != Op1[WIDTH-1]);
      end
      5'h04: w_lo = Op1 & Op2;
      5'h05: begin
        w_lo   = w_diff;
        w_ovf  = (Op2[WIDTH-1] != Op1[WIDTH-1]) && (w_diff[WIDTH-1] != Op2[WIDTH-1]);
        w_zero = w_diff == '0;
      end
      5'h06: w_lo = Op2 << shamt;
      5'h07: w_lo = Op2 >> shamt;
      5'h08: w_lo = WIDTH'($signed(Op1) < $signed(Op2));
      5'h09: w_lo = WIDTH'(Op1 < Op2);
      5'h0a: w_lo = ~(Op1 | Op2);
      5'h0b: w_lo = Op2;
      5'h0e: w_lo = $unsigned($signed(Op2) >>> shamt);
`ifdef ALU_MULTICYCLE_DIV_EN
      5'h10: if (Op2 == '0) begin
        w_lo = '1;
        w_hi = Op1;
        w_dz = 1'b1;
      end
`endif
      5'h16: w_lo = Op1;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  // Next-state: accept in IDLE, iterate WIDTH cycles in MUL/DIV, hand off in DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_start;
      MUL:  if (w_last) w_next = DONE;
`ifdef ALU_MULTICYCLE_DIV_EN
      DIV:  if (w_last) w_next = DONE;
`endif
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, multiply/divide iterations and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_res  <= '0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
      r_dz   <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_a    <= Op1;
      r_hi   <= '0;
      r_lo   <= w_lo_init;
      r_res  <= {w_hi, w_lo};
      r_zero <= w_zero;
      r_ovf  <= w_ovf;
      r_dz   <= w_dz;
    end else if (r_state == MUL) begin
      r_cnt        <= r_cnt + 1'b1;
      {r_hi, r_lo} <= w_mnext;
      if (w_last) begin
        r_res  <= w_mnext;
        r_zero <= w_mnext == '0;
        r_ovf  <= 1'b0;
        r_dz   <= 1'b0;
      end
    end
`ifdef ALU_MULTICYCLE_DIV_EN
    else if (r_state == DIV) begin
      r_cnt <= r_cnt + 1'b1;
      r_hi  <= w_dhi;
      r_lo  <= w_dlo;
      if (w_last) begin
        r_res  <= {w_r, w_q};
        r_zero <= {w_r, w_q} == '0;
        r_ovf  <= r_dovf;
        r_dz   <= 1'b0;
      end
    end
`endif
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and randomized checks of alu_multicycle against an arithmetic reference model
module tb_alu_multicycle;
  localparam longint MAXI = 64'sh7FFFFFFF;
  localparam longint MINI = -64'sh80000000;
`ifdef ALU_MULTICYCLE_DIV_EN
  localparam logic [4:0] LONG_OP = 5'h10;
`else
  localparam logic [4:0] LONG_OP = 5'h0f;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  operation = '0;
  logic [31:0] Op1 = '0;
  logic [31:0] Op2 = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] EXE_Result;
  logic        EXE_Zero, Overflow, div_zero;
  int          total = 0;
  int          bad = 0;
  logic [4:0]  ops [18] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                            5'h0a, 5'h0b, 5'h0e, 5'h0f, 5'h10, 5'h16, 5'h00, 5'h11, 5'h1f};

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .Op1(Op1), .Op2(Op2), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .EXE_Result(EXE_Result),
    .EXE_Zero(EXE_Zero), .Overflow(Overflow), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result computed with wide integer arithmetic; lat is cycles from accept to out_valid
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [63:0] r, output logic z,
                                output logic o, output logic d, output int lat);
    longint sa, sb, s, q, m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = 0; q = 0; m = 0;
    r = '0; z = 1'b0; o = 1'b0; d = 1'b0; lat = 1;
    case (op)
      5'h01: r = {32'b0, b << 16};
      5'h02: r = {32'b0, a | b};
      5'h03: begin
        s = sa + sb;
        r = {32'b0, s[31:0]};
        o = s > MAXI || s < MINI;
      end
      5'h04: r = {32'b0, a & b};
      5'h05: begin
        s = sb - sa;
        r = {32'b0, s[31:0]};
        o = s > MAXI || s < MINI;
        z = s[31:0] == 32'd0;
      end
      5'h06: r = {32'b0, b << sh};
      5'h07: r = {32'b0, b >> sh};
      5'h08: r = 64'(sa < sb);
      5'h09: r = 64'(a < b);
      5'h0a: r = {32'b0, ~(a | b)};
      5'h0b: r = {32'b0, b};
      5'h0e: begin
        s = sb >>> sh;
        r = {32'b0, s[31:0]};
      end
      5'h0f: begin
        r = {32'b0, a} * {32'b0, b};
        z = r == 64'd0;
        lat = 33;
      end
`ifdef ALU_MULTICYCLE_DIV_EN
      5'h10: if (b == 32'd0) begin
        r = {a, 32'hFFFFFFFF};
        d = 1'b1;
      end else begin
        q = sa / sb;
        m = sa % sb;
        r = {m[31:0], q[31:0]};
        o = q > MAXI;
        z = r == 64'd0;
        lat = 33;
      end
`endif
      5'h16: r = {32'b0, a};
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: pick = $urandom;
      1: pick = 32'($urandom_range(0, 3));
      2: pick = $urandom_range(0, 1) ? 32'h80000000 : 32'h7FFFFFFF;
      default: pick = 32'hFFFFFFFF - 32'($urandom_range(0, 2));
    endcase
  endfunction

  // One request: issue, keep in_valid high with junk while busy, check result, stall, release
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input int hold);
    logic [63:0] er;
    logic        ez, eo, ed, busy_bad;
    int          el, n;
    model(op, a, b, sh, er, ez, eo, ed, el);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; operation = op; Op1 = a; Op2 = b; shamt = sh;
    @(posedge clk);
    #1;
    operation = 5'($urandom); Op1 = $urandom; Op2 = $urandom; shamt = 5'($urandom);
    n = 0;
    busy_bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid && in_ready) busy_bad = 1'b1;
    end while (!out_valid && n < 200);
    in_valid = 1'b0;
    chk($sformatf("latency op%0h", op), 64'(n), 64'(el));
    chk("busy_in_ready", 64'(busy_bad), 64'd0);
    chk($sformatf("result op%0h a=%0h b=%0h", op, a, b), EXE_Result, er);
    chk($sformatf("zero op%0h", op), 64'(EXE_Zero), 64'(ez));
    chk($sformatf("ovf op%0h", op), 64'(Overflow), 64'(eo));
    chk($sformatf("div_zero op%0h", op), 64'(div_zero), 64'(ed));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", EXE_Result, er);
      chk("hold_flags", 64'({EXE_Zero, Overflow, div_zero}), 64'({ez, eo, ed}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", 64'(out_valid), 64'd0);
    chk("release_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", EXE_Result, 64'd0);
    chk("rst_zero", 64'(EXE_Zero), 64'd0);
    chk("rst_ovf", 64'(Overflow), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(5'h03, 32'h7FFFFFFF, 32'h00000001, 5'd0, 0);
    do_op(5'h05, 32'd5, 32'd5, 5'd0, 0);
    do_op(5'h05, 32'd1, 32'h80000000, 5'd0, 1);
    do_op(5'h0f, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 0);
    do_op(5'h0f, 32'd0, 32'h12345678, 5'd0, 0);
    do_op(5'h10, 32'hFFFFFFF9, 32'd2, 5'd0, 0);
    do_op(5'h10, 32'hFFFFFFF9, 32'd0, 5'd0, 1);
    do_op(5'h10, 32'h80000000, 32'hFFFFFFFF, 5'd0, 0);
    do_op(5'h10, 32'd100, 32'hFFFFFFF9, 5'd0, 0);
    do_op(5'h0e, 32'd0, 32'h80000000, 5'd4, 5);
    do_op(5'h01, 32'd0, 32'h0001ABCD, 5'd0, 0);
    do_op(5'h16, 32'hCAFEF00D, 32'd0, 5'd0, 0);
    do_op(5'h1f, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 0);

    @(negedge clk);
    in_valid = 1'b1; operation = LONG_OP; Op1 = 32'h12345678; Op2 = 32'h00000345;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_rst_valid", 64'(out_valid), 64'd0);
    chk("midop_rst_result", EXE_Result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midop_ready_after", 64'(in_ready), 64'd1);
    do_op(5'h02, 32'hF0F00000, 32'h00000F0F, 5'd0, 0);

    for (int i = 0; i < 40; i++)
      do_op(ops[$urandom_range(0, 17)], pick(), pick(), 5'($urandom), int'($urandom_range(0, 2)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
